// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: feeds an external 1-bit full-adder cell LSB first,
// one bit per clock, and collects the sum, final carry and signed overflow.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_ci,
  input  logic             bit_f,
  input  logic             bit_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Co,
  output logic             OV
);

  // Handshake: start is a request honoured only in IDLE; busy is high for the
  // WIDTH RUN cycles; done is a single-cycle pulse during which F/Co/OV are valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    bit_a     = 1'b0;
    bit_b     = 1'b0;
    bit_ci    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy   = 1'b1;
        bit_a  = a_sh[0];
        bit_b  = b_sh[0];
        bit_ci = c_reg;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
      F      <= '0;
      Co     <= 1'b0;
      OV     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= A;
          b_sh   <= B;
          c_reg  <= Ci;
          cnt    <= '0;
          sum_sh <= '0;
        end
        RUN: begin
          sum_sh <= {bit_f, sum_sh[WIDTH-1:1]};
          c_reg  <= bit_co;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          // Results update only on the final bit so F/Co/OV never show partial sums.
          if (last_bit) begin
            F  <= {bit_f, sum_sh[WIDTH-1:1]};
            Co <= bit_co;
            OV <= bit_ci ^ bit_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: models the full-adder cell, drives directed and
// random adds, and compares against an arithmetic reference of the sum.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         Ci;
  logic         bit_a, bit_b, bit_ci, bit_f, bit_co;
  logic         busy, done;
  logic [W-1:0] F;
  logic         Co, OV;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev_f;
  logic         prev_co, prev_ov;

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Ci(Ci),
    .bit_a(bit_a), .bit_b(bit_b), .bit_ci(bit_ci), .bit_f(bit_f), .bit_co(bit_co),
    .busy(busy), .done(done), .F(F), .Co(Co), .OV(OV)
  );

  // Full-adder cell sitting outside the controller
  assign bit_f  = bit_a ^ bit_b ^ bit_ci;
  assign bit_co = (bit_a & bit_b) | (bit_a & bit_ci) | (bit_b & bit_ci);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output logic [W-1:0] f, output logic co, output logic ov);
    longint s;
    s  = longint'(a) + longint'(b) + longint'(ci);
    f  = W'(s);
    co = s[W];
    ov = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
  endtask

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input bit mid_pulse);
    logic [W-1:0] ef;
    logic         eco, eov;
    longint       m, cin;
    int           cyc;
    ref_add(a, b, ci, ef, eco, eov);
    @(negedge clk); A = a; B = b; Ci = ci; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3 * W) begin
      if (cyc < W) begin
        m   = (longint'(1) << cyc) - 1;
        cin = (((longint'(a) & m) + (longint'(b) & m) + longint'(ci)) >> cyc) & 1;
        check("run_busy", busy, 1);
        check("bit_a", bit_a, a[cyc]);
        check("bit_b", bit_b, b[cyc]);
        check("bit_ci", bit_ci, cin[0]);
        check("f_hold", F, prev_f);
        check("co_hold", Co, prev_co);
        check("ov_hold", OV, prev_ov);
      end
      start = mid_pulse && (cyc == 3);
      if (mid_pulse && cyc == 3) A = 8'h11;
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, W);
    check("done_busy", busy, 0);
    check("F", F, ef);
    check("Co", Co, eco);
    check("OV", OV, eov);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_bits", {bit_a, bit_b, bit_ci}, 0);
    check("F_after", F, ef);
    prev_f = ef; prev_co = eco; prev_ov = eov;
  endtask

  task automatic reset_mid_run();
    @(negedge clk); A = 8'h5A; B = 8'h3C; Ci = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_F", F, 0);
    check("rst_CoOV", {Co, OV}, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_bits", {bit_a, bit_b, bit_ci}, 0);
    prev_f = '0; prev_co = 1'b0; prev_ov = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {busy, done}, 0);
  endtask

  task automatic hold_start();
    int last_c, n;
    last_c = -1;
    n = 0;
    @(negedge clk); A = 8'h01; B = 8'h01; Ci = 1'b0; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        check("hold_F", F, 8'h02);
        if (last_c >= 0) check("hold_period", c - last_c, W + 2);
        last_c = c;
        n++;
      end
    end
    start = 1'b0;
    check("hold_done_count", n, 3);
    repeat (W + 3) @(negedge clk);
    check("hold_idle", {busy, done}, 0);
    prev_f = 8'h02; prev_co = 1'b0; prev_ov = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
    prev_f = '0; prev_co = 1'b0; prev_ov = 1'b0;
    #2;
    check("reset_F", F, 0);
    check("reset_CoOV", {Co, OV}, 0);
    check("reset_busy_done", {busy, done}, 0);
    check("reset_bits", {bit_a, bit_b, bit_ci}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_add(8'h5A, 8'h3C, 1'b0, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0, 1'b0);
    do_add(8'hFF, 8'h00, 1'b1, 1'b0);
    do_add(8'h80, 8'h80, 1'b0, 1'b0);
    do_add(8'h7F, 8'h00, 1'b1, 1'b0);
    do_add(8'h01, 8'h01, 1'b0, 1'b1);
    reset_mid_run();
    do_add(8'h03, 8'h04, 1'b0, 1'b0);
    hold_start();
    for (int i = 0; i < 20; i++)
      do_add(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
